mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Iterative RV32M multiply/divide unit with its own sequencing FSM, sitting beside the ALU in the EX stage. The decode path raises `start` when an R-type instruction with funct7 = 7'b0000001 reaches EX. The block holds the pipeline with `stall` while it runs one radix-2 step per cycle, then presents `result` for write-back. Divide-by-zero and signed overflow are resolved early, without iterating.

## Interface
- `XLEN`, default 32. Operand and result width; must be a power of two ≥ 8.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `flush`  in  1  abort the in-flight operation (branch/jump flush from hazard logic).
- `funct3`  in  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  XLEN  rs1 value; multiplicand or dividend.
- `op_b`  in  XLEN  rs2 value; multiplier or divisor.
- `busy`  out  1  registered; high in CALC.
- `done`  out  1  registered one-cycle pulse; `result` valid.
- `stall`  out  1  combinational; `(start & state==IDLE & ~flush) | busy`; freezes IF/ID/EX.
- `result`  out  XLEN  registered; holds the last completed value until the next completion.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: iterates; counter runs XLEN−1 down to 0.
  - DONE: single cycle with `done`=1.
- IDLE with `start`=1 and `flush`=0:
  - Latch `funct3`.
  - Latch operand magnitudes: signed ops take the absolute value of signed operands.
  - Latch result-sign flags.
  - Special cases go straight to DONE; all other ops go to CALC.
- CALC, multiply: shift-add over a 2·XLEN accumulator, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first; XLEN+1-bit partial remainder.
- When the counter is 0 in CALC, move to DONE. In that cycle, apply the sign fix and select the output:
  - MUL: low half.
  - MULH, MULHSU, MULHU: high half.
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
- Sign rules:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - MULHSU treats only `op_a` as signed.
- Special cases (RISC-V spec), latency 1:
  - Divisor zero: DIV/DIVU give all ones; REM/REMU give `op_a`.
  - Signed overflow (`op_a`=most negative, `op_b`=−1): DIV gives `op_a`; REM gives 0.
- DONE always returns to IDLE the next cycle. Back-to-back `start` is honoured in that IDLE cycle.
- `start` in CALC or DONE is ignored; the requester must hold it until it sees `done`.
- `flush` in CALC: next state IDLE, `busy`→0, no `done`, `result` unchanged.
- `flush` in DONE: `done` still pulses; hazard logic discards the write-back.
- `flush` and `start` together in IDLE: `flush` wins; stay IDLE.
- Illegal state encoding: go to IDLE.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, counter=0, accumulators=0.
- `rst` mid-operation: back to IDLE next edge; no `done`.
- Iterative op latency: `start` sampled at edge N → `busy` high for edges N+1..N+XLEN → `done` high after edge N+XLEN+1. That is XLEN+1 cycles of `stall`, i.e. 33 cycles at XLEN=32.
- Special-case latency: `done` high after edge N+1; `stall` high for the single cycle N only.
- `stall` is low in the DONE cycle, so EX/MEM captures `result` on the edge ending DONE.
- No combinational path from `op_a`/`op_b` to any output.

## Structure
- Shared package `riscv_pkg`:
  - OPCODE_RTYPE = 7'b0110011 and FUNCT7_MULDIV = 7'b0000001.
  - funct3 localparams F3_MUL…F3_REMU.
  - State enum `mdu_state_t` (IDLE, CALC, DONE).
- Sub-module `mdu_iter_core`:
  - Contains the accumulator, partial remainder and shift/subtract step.
  - Driven by the load, step and is_div strobes from the FSM in `mdu_sequencer`.
  - Returns raw high half, low half, quotient and remainder.
- Sign pre/post-processing and special-case detection stay in `mdu_sequencer`.

## Test plan
- Reset during CALC (cycle 10 of a DIVU): state IDLE next cycle; `busy`=0, `done`=0, `result`=0; no `done` pulse afterwards.
- MUL 7 × −3 (0xFFFFFFFD): `done` 33 cycles after `start`; `result`=0xFFFFFFEB. Then MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7 ÷ 2 → 0xFFFFFFFD; REM −7 ÷ 2 → 0xFFFFFFFF; DIVU 100 ÷ 7 → 14; REMU 100 ÷ 7 → 2. Check `stall` is high for exactly 33 cycles each.
- DIVU 5 ÷ 0 → 0xFFFFFFFF and REMU 5 ÷ 0 → 5; DIV 0x80000000 ÷ −1 → 0x80000000 and REM → 0. Each must show `done` one cycle after `start` with `busy` never high.
- `flush` at cycle 5 of CALC: `busy` low next cycle, no `done`, `result` keeps its previous value. `start` then accepted immediately and completes normally.
- Back-to-back: a second `start` held through the first op's DONE is accepted in the following IDLE cycle. Both `done` pulses appear, 34 cycles apart; `start` pulses during CALC have no effect.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the M-extension sequencer state type.
// The helper functions classify funct3 for operand signedness and divide/multiply.
package riscv_pkg;

    localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic op_a_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Radix-2 shift-add multiply / restoring divide datapath on unsigned magnitudes.
// hi_next/lo_next show the register contents after the current step completes.
module mdu_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] opnd,
    input  logic [XLEN-1:0] seed,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    // hi: product high half or partial remainder; lo: multiplier bits or quotient bits
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic            fits;
    logic [XLEN-1:0] hi_step, lo_step;

    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        fits    = shifted >= {1'b0, opnd_q};
        if (is_div) begin
            // The kept remainder is below the divisor, so XLEN bits hold the difference.
            hi_step = fits ? (shifted[XLEN-1:0] - opnd_q) : shifted[XLEN-1:0];
            lo_step = {lo_q[XLEN-2:0], fits};
        end else begin
            hi_step = sum[XLEN:1];
            lo_step = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        if (load) begin
            hi_d   = '0;
            lo_d   = seed;
            opnd_d = opnd;
        end else if (step) begin
            hi_d = hi_step;
            lo_d = lo_step;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so all registers update together.
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
        end
    end

    assign hi_next = hi_step;
    assign lo_next = lo_step;

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M iterative multiply/divide sequencer: operand sign handling, early-out
// special cases, IDLE/CALC/DONE control and the registered result.
module mdu_sequencer
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic            stall,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t      state_q, state_d;
    logic            busy_q, done_q;
    logic [2:0]      f3_q, f3_d;
    logic            quo_neg_q, quo_neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            accept, load, step;
    logic            a_neg, b_neg, div_by_zero, overflow, special;
    logic [XLEN-1:0] a_mag, b_mag, special_val;
    logic [XLEN-1:0] core_hi, core_lo;
    logic [2*XLEN-1:0] prod_raw, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, final_val;

    always_comb begin
        a_neg       = op_a_signed(funct3) & op_a[XLEN-1];
        b_neg       = op_b_signed(funct3) & op_b[XLEN-1];
        a_mag       = a_neg ? -op_a : op_a;
        b_mag       = b_neg ? -op_b : op_b;
        div_by_zero = is_div_op(funct3) && (op_b == '0);
        overflow    = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (op_a == MOST_NEG) && (op_b == '1);
        special     = div_by_zero | overflow;
        if (div_by_zero) special_val = funct3[1] ? op_a : '1;
        else             special_val = funct3[1] ? '0 : op_a;
    end

    mdu_iter_core #(.XLEN(XLEN)) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .is_div  (is_div_op(f3_q)),
        .opnd    (is_div_op(funct3) ? b_mag : a_mag),
        .seed    (is_div_op(funct3) ? a_mag : b_mag),
        .hi_next (core_hi),
        .lo_next (core_lo)
    );

    // Sign fix-up uses the post-step values so the final step lands in result directly.
    always_comb begin
        prod_raw = {core_hi, core_lo};
        prod_fix = quo_neg_q ? -prod_raw : prod_raw;
        quo_fix  = quo_neg_q ? -core_lo : core_lo;
        rem_fix  = rem_neg_q ? -core_hi : core_hi;
        case (f3_q)
            F3_MUL:                       final_val = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: final_val = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              final_val = quo_fix;
            default:                      final_val = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == CALC);
            done_q  <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && !flush) state_d = special ? DONE : CALC;
            CALC: begin
                if (flush)             state_d = IDLE;
                else if (cnt_q == '0)  state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept = start && !flush && (state_q == IDLE);
        load   = accept && !special;
        step   = (state_q == CALC) && !flush;
        stall  = accept || busy_q;
    end

    always_comb begin
        f3_d      = f3_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        if (accept) begin
            f3_d      = funct3;
            quo_neg_d = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            cnt_d     = CW'(XLEN - 1);
            if (special) result_d = special_val;
        end else if (step) begin
            if (cnt_q != '0) cnt_d    = cnt_q - 1'b1;
            else             result_d = final_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f3_q      <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            f3_q      <= f3_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed corner cases plus random ops
// compared against a plain-arithmetic RV32M reference model.
module tb_mdu_sequencer;
    import riscv_pkg::*;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        busy, done, stall;
    logic [31:0] result;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc, gap;
    logic seen;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    mdu_sequencer #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Issues one op from an IDLE cycle, holds start until done, measures latency and stall.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int   n, stalls;
        logic busy_seen, special;
        special = f3[2] && (b == 32'd0 ||
                  (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        funct3 = f3; op_a = a; op_b = b; start = 1'b1;
        n = 0; stalls = 0; busy_seen = 1'b0;
        while (done !== 1'b1 && n < 200) begin
            #1;
            if (stall === 1'b1) stalls++;
            if (busy === 1'b1) busy_seen = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), special ? 32'd1 : 32'd33);
        check({tag, " stall_cycles"}, 32'(stalls), special ? 32'd1 : 32'd33);
        check({tag, " stall_in_done"}, {31'b0, stall}, 32'd0);
        check({tag, " busy_seen"}, {31'b0, busy_seen}, {31'b0, !special});
        check({tag, " result"}, result, exp);
        start = 1'b0;
        tick();
        check({tag, " done_one_cycle"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0;
        tick();
        tick();
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset stall", {31'b0, stall}, 32'd0);
        rst = 1'b0;
        tick();

        // Directed values
        run_op("mul_7_m3", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh_min_min", F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhu_max_max", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7, 32'd14);
        run_op("remu_100_7", F3_REMU, 32'd100, 32'd7, 32'd2);
        run_op("divu_by_0", F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_by_0", F3_REMU, 32'd5, 32'd0, 32'd5);
        run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Flush at CALC cycle 5; result keeps 0 from rem_ovf
        funct3 = F3_MUL; op_a = 32'd123; op_b = 32'd456; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", {31'b0, busy}, 32'd0);
        check("flush done", {31'b0, done}, 32'd0);
        check("flush result", result, 32'd0);
        check("flush stall", {31'b0, stall}, 32'd0);
        run_op("after_flush_mul", F3_MUL, 32'd123, 32'd456, 32'd56088);

        // flush and start together in IDLE: flush wins
        funct3 = F3_DIVU; op_a = 32'd9; op_b = 32'd3; start = 1'b1; flush = 1'b1;
        #1;
        check("flush_start stall", {31'b0, stall}, 32'd0);
        tick();
        start = 1'b0; flush = 1'b0;
        check("flush_start busy", {31'b0, busy}, 32'd0);
        check("flush_start done", {31'b0, done}, 32'd0);

        // Reset during CALC of DIVU, after a non-zero result is held
        run_op("divu_pre_rst", F3_DIVU, 32'd1000, 32'd3, 32'd333);
        funct3 = F3_DIVU; op_a = 32'd77; op_b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid busy", {31'b0, busy}, 32'd0);
        check("rst_mid done", {31'b0, done}, 32'd0);
        check("rst_mid result", result, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        check("rst_mid no_done", {31'b0, seen}, 32'd0);

        // Back-to-back: start held through first DONE and all of CALC
        funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("b2b first latency", 32'(cyc), 32'd33);
        check("b2b first result", result, 32'd14);
        funct3 = F3_REMU; op_a = 32'd100; op_b = 32'd7;
        gap = 0;
        do begin
            tick();
            gap++;
        end while (done !== 1'b1 && gap < 200);
        check("b2b done spacing", 32'(gap), 32'd34);
        check("b2b second result", result, 32'd2);
        start = 1'b0;
        tick();
        tick();
        check("b2b idle busy", {31'b0, busy}, 32'd0);
        check("b2b idle done", {31'b0, done}, 32'd0);

        // Random ops against the reference model
        for (int i = 0; i < 30; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 255)); rb = 32'($urandom_range(1, 15)); end
                3: begin ra = -32'($urandom_range(1, 1000)); rb = 32'($urandom_range(1, 50)); end
                4: rb = -32'($urandom_range(1, 1000));
                default: ;
            endcase
            run_op($sformatf("rnd%0d_f3_%0d", i, rf3), rf3, ra, rb, ref_model(rf3, ra, rb));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
